// File: rtl/adc_if_pkg.sv
// Shared constants, types and register-file defaults for the ADC serial responder.
// Frame layout (MSB first): [31:20] header, [19:16] register address, [15:0] data.
package adc_if_pkg;

  localparam int FRAME_BITS = 32;
  localparam int HDR_LSB    = 20;
  localparam int ADDR_MSB   = 19;
  localparam int ADDR_LSB   = 16;
  localparam int DATA_MSB   = 15;
  localparam int DATA_LSB   = 0;

  localparam logic [11:0] HEADER = 12'h001;

  typedef logic [3:0]            reg_addr_t;
  typedef logic [15:0]           reg_data_t;
  typedef logic [5:0]            bit_cnt_t;
  typedef logic [FRAME_BITS-1:0] frame_t;

  localparam reg_addr_t REG_CONFIG   = 4'h1;
  localparam reg_addr_t REG_I_OFFSET = 4'h2;
  localparam reg_addr_t REG_I_FSR    = 4'h3;
  localparam reg_addr_t REG_Q_OFFSET = 4'hA;
  localparam reg_addr_t REG_Q_FSR    = 4'hB;

  localparam reg_data_t DEF_CONFIG   = 16'hB2FF;
  localparam reg_data_t DEF_I_OFFSET = 16'h007F;
  localparam reg_data_t DEF_I_FSR    = 16'h807F;
  localparam reg_data_t DEF_Q_OFFSET = 16'h007F;
  localparam reg_data_t DEF_Q_FSR    = 16'h807F;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SHIFT      = 2'd1,
    WAIT_DESEL = 2'd2
  } frame_state_e;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_WAIT = 2'd1,
    C_RUN  = 2'd2
  } cal_state_e;

  function automatic reg_data_t reg_default(input reg_addr_t addr);
    reg_data_t value;
    unique case (addr)
      REG_CONFIG:   value = DEF_CONFIG;
      REG_I_OFFSET: value = DEF_I_OFFSET;
      REG_I_FSR:    value = DEF_I_FSR;
      REG_Q_OFFSET: value = DEF_Q_OFFSET;
      REG_Q_FSR:    value = DEF_Q_FSR;
      default:      value = '0;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/adc_serial_responder_sync_edge.sv
// Two-flop synchronizer with a third stage for edge detection.
// Edge flags are registered so level, rise and fall all change on the same edge.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q, sync_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[1:0], d};
    rise_d = sync_q[1] & ~sync_q[2];
    fall_d = ~sync_q[1] & sync_q[2];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = sync_q[2];
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/adc_serial_responder.sv
// ADC-side stand-in: decodes 32-bit serial write frames into a 16x16 register
// file and runs the calibration handshake with power-down abort.
module adc_serial_responder
  import adc_if_pkg::*;
#(
  parameter int unsigned CAL_DELAY        = 4,
  parameter int unsigned CAL_CYCLES       = 14,
  parameter bit          AUTO_CAL_ON_WAKE = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        InSclk,
  input  logic        InSdata,
  input  logic        InSelect,
  input  logic        InPD,
  input  logic        InPDQ,
  input  logic        InCal,
  input  logic [3:0]  RdAddr,
  output logic [15:0] RdData,
  output logic        OutCalRunning,
  output logic        FrameDone,
  output logic        FrameError,
  output logic        PoweredDown
);

  localparam int N_SYNC  = 6;
  localparam int S_SCLK  = 0;
  localparam int S_SDATA = 1;
  localparam int S_SEL   = 2;
  localparam int S_PD    = 3;
  localparam int S_PDQ   = 4;
  localparam int S_CAL   = 5;

  localparam int unsigned CAL_MAX   = (CAL_DELAY > CAL_CYCLES) ? CAL_DELAY : CAL_CYCLES;
  localparam int          CAL_CNT_W = $clog2(CAL_MAX + 1);
  typedef logic [CAL_CNT_W-1:0] cal_cnt_t;

  // ---------------------------------------------------------------- input sync
  logic [N_SYNC-1:0] sync_raw, sync_lvl, sync_rise, sync_fall;

  assign sync_raw = {InCal, InPDQ, InPD, InSelect, InSdata, InSclk};

  for (genvar i = 0; i < N_SYNC; i++) begin : g_sync
    sync_edge u_sync (
      .clk   (Clock),
      .rst   (Reset),
      .d     (sync_raw[i]),
      .level (sync_lvl[i]),
      .rise  (sync_rise[i]),
      .fall  (sync_fall[i])
    );
  end

  logic unused_sync;
  assign unused_sync = ^{sync_lvl, sync_rise, sync_fall};

  logic sclk_rise, sdata_lvl, sel_fall, sel_rise, pd_lvl, pd_fall, pdq_lvl, cal_rise;
  assign sclk_rise = sync_rise[S_SCLK];
  assign sdata_lvl = sync_lvl[S_SDATA];
  assign sel_fall  = sync_fall[S_SEL];
  assign sel_rise  = sync_rise[S_SEL];
  assign pd_lvl    = sync_lvl[S_PD];
  assign pd_fall   = sync_fall[S_PD];
  assign pdq_lvl   = sync_lvl[S_PDQ];
  assign cal_rise  = sync_rise[S_CAL];

  // ---------------------------------------------------------------- state
  frame_state_e frame_state_q, frame_state_d;
  bit_cnt_t     bit_cnt_q, bit_cnt_d;
  frame_t       shift_q, shift_d;
  logic         wr_en_q, wr_en_d;
  reg_addr_t    wr_addr_q, wr_addr_d;
  reg_data_t    wr_data_q, wr_data_d;
  logic         frame_err_q, frame_err_d;
  cal_state_e   cal_state_q, cal_state_d;
  cal_cnt_t     cal_cnt_q, cal_cnt_d;
  logic         powered_down_q, powered_down_d;
  reg_data_t    regs_q [16];
  reg_data_t    regs_d [16];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      frame_state_q  <= IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      frame_err_q    <= 1'b0;
      cal_state_q    <= C_IDLE;
      cal_cnt_q      <= '0;
      powered_down_q <= 1'b0;
    end else begin
      frame_state_q  <= frame_state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      frame_err_q    <= frame_err_d;
      cal_state_q    <= cal_state_d;
      cal_cnt_q      <= cal_cnt_d;
      powered_down_q <= powered_down_d;
    end
  end

  // NOTE: the register file is reset explicitly because it must come up holding
  // the ADC defaults; it is small enough to live in flops rather than a RAM.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= reg_default(reg_addr_t'(i));
    end else begin
      regs_q <= regs_d;
    end
  end

  // Commit lags FrameDone's source by one edge so RdData updates after the pulse.
  always_comb begin
    regs_d = regs_q;
    if (wr_en_q) regs_d[wr_addr_q] = wr_data_q;
  end

  // ---------------------------------------------------------------- frame FSM
  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    frame_state_d = frame_state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_err_d   = 1'b0;

    unique case (frame_state_q)
      IDLE: begin
        if (sel_fall) begin
          frame_state_d = SHIFT;
          bit_cnt_d     = '0;
          shift_d       = '0;
        end
      end
      SHIFT: begin
        // A coincident Select rise sees the frame including this bit.
        if (sclk_rise) begin
          shift_d   = {shift_q[FRAME_BITS-2:0], sdata_lvl};
          bit_cnt_d = bit_cnt_q + bit_cnt_t'(1);
        end
        if (sel_rise) begin
          frame_state_d = IDLE;
          if (bit_cnt_d == bit_cnt_t'(FRAME_BITS) &&
              shift_d[FRAME_BITS-1:HDR_LSB] == HEADER) begin
            wr_en_d   = 1'b1;
            wr_addr_d = shift_d[ADDR_MSB:ADDR_LSB];
            wr_data_d = shift_d[DATA_MSB:DATA_LSB];
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (bit_cnt_d == bit_cnt_t'(FRAME_BITS + 1)) begin
          frame_err_d   = 1'b1;
          frame_state_d = WAIT_DESEL;
        end
      end
      WAIT_DESEL: begin
        if (sel_rise) frame_state_d = IDLE;
      end
      default: frame_state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- cal FSM
  always_comb begin
    cal_state_d = cal_state_q;
    cal_cnt_d   = cal_cnt_q;

    unique case (cal_state_q)
      C_IDLE: begin
        if ((cal_rise && !pd_lvl) || (AUTO_CAL_ON_WAKE && pd_fall)) begin
          cal_state_d = C_WAIT;
          cal_cnt_d   = cal_cnt_t'(CAL_DELAY - 1);
        end
      end
      C_WAIT: begin
        if (pd_lvl) begin
          cal_state_d = C_IDLE;
        end else if (cal_cnt_q == '0) begin
          cal_state_d = C_RUN;
          cal_cnt_d   = cal_cnt_t'(CAL_CYCLES - 1);
        end else begin
          cal_cnt_d = cal_cnt_q - cal_cnt_t'(1);
        end
      end
      C_RUN: begin
        if (pd_lvl || cal_cnt_q == '0) begin
          cal_state_d = C_IDLE;
        end else begin
          cal_cnt_d = cal_cnt_q - cal_cnt_t'(1);
        end
      end
      default: cal_state_d = C_IDLE;
    endcase
  end

  assign powered_down_d = pd_lvl & pdq_lvl;

  // ---------------------------------------------------------------- outputs
  always_comb begin
    RdData        = regs_q[RdAddr];
    OutCalRunning = (cal_state_q == C_RUN);
    FrameDone     = wr_en_q;
    FrameError    = frame_err_q;
    PoweredDown   = powered_down_q;
  end

endmodule

// File: tb/tb_adc_serial_responder.sv
// Self-checking bench for adc_serial_responder: table-driven frames, random
// frames against a register-file model, and hand-written calibration/reset sequences.
module tb_adc_serial_responder;

  localparam int CAL_DELAY  = 4;
  localparam int CAL_CYCLES = 14;
  localparam int CAL_LAT    = CAL_DELAY + 3;

  logic        Clock    = 1'b0;
  logic        Reset    = 1'b1;
  logic        InSclk   = 1'b0;
  logic        InSdata  = 1'b0;
  logic        InSelect = 1'b1;
  logic        InPD     = 1'b0;
  logic        InPDQ    = 1'b0;
  logic        InCal    = 1'b0;
  logic [3:0]  RdAddr   = 4'h0;
  logic [15:0] RdData;
  logic        OutCalRunning, FrameDone, FrameError, PoweredDown;

  adc_serial_responder #(
    .CAL_DELAY        (CAL_DELAY),
    .CAL_CYCLES       (CAL_CYCLES),
    .AUTO_CAL_ON_WAKE (1'b1)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .InSclk        (InSclk),
    .InSdata       (InSdata),
    .InSelect      (InSelect),
    .InPD          (InPD),
    .InPDQ         (InPDQ),
    .InCal         (InCal),
    .RdAddr        (RdAddr),
    .RdData        (RdData),
    .OutCalRunning (OutCalRunning),
    .FrameDone     (FrameDone),
    .FrameError    (FrameError),
    .PoweredDown   (PoweredDown)
  );

  always #5 Clock = ~Clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  int          err_cnt  = 0;
  bit          cap_pending = 1'b0;
  logic [15:0] rd_cap;
  logic [15:0] model_regs [16];

  // Pulse counters: a stretched pulse counts more than once.
  always @(negedge Clock) begin
    if (cap_pending) begin
      rd_cap      = RdData;
      cap_pending = 1'b0;
    end
    if (FrameDone) begin
      done_cnt++;
      cap_pending = 1'b1;
    end
    if (FrameError) err_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] spec_default(input logic [3:0] a);
    case (a)
      4'h1:    return 16'hB2FF;
      4'h2:    return 16'h007F;
      4'h3:    return 16'h807F;
      4'hA:    return 16'h007F;
      4'hB:    return 16'h807F;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_regs[i] = spec_default(4'(i));
  endtask

  task automatic pulse_reset();
    @(negedge Clock);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  // Sclk = Clock/8: 4 cycles low with data set up, 4 cycles high.
  task automatic send_bit(input logic b, input bit sel_with_rise);
    InSdata = b;
    InSclk  = 1'b0;
    repeat (4) @(negedge Clock);
    InSclk = 1'b1;
    if (sel_with_rise) InSelect = 1'b1;
    repeat (4) @(negedge Clock);
  endtask

  task automatic send_frame(input logic [63:0] bits, input int n, input bit simul);
    InSelect = 1'b0;
    repeat (8) @(negedge Clock);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i], simul && (i == 0));
    InSclk = 1'b0;
    repeat (4) @(negedge Clock);
    InSelect = 1'b1;
    repeat (16) @(negedge Clock);
  endtask

  task automatic run_frame(input string name, input logic [63:0] bits, input int n,
                           input bit simul, input logic [3:0] addr,
                           input int exp_done, input int exp_err);
    int d0;
    int e0;
    d0     = done_cnt;
    e0     = err_cnt;
    RdAddr = addr;
    rd_cap = 'x;
    send_frame(bits, n, simul);
    check({name, " done_pulses"}, done_cnt - d0, exp_done);
    check({name, " err_pulses"}, err_cnt - e0, exp_err);
    if (exp_done == 1) begin
      model_regs[bits[19:16]] = bits[15:0];
      check({name, " rd_after_done"}, 32'(rd_cap), 32'(bits[15:0]));
    end
    check({name, " rd_reg"}, 32'(RdData), 32'(model_regs[addr]));
  endtask

  // Samples OutCalRunning on each negedge after the stimulus edge (index 0 is
  // the edge that first sampled the trigger) and applies scheduled input changes.
  task automatic observe_cal(input int ncyc, input int cal_off_at, input int cal_on2,
                             input int cal_off2, input int pd_on_after,
                             output int first, output int last, output int highs);
    first = -1;
    last  = -1;
    highs = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge Clock);
      if (OutCalRunning) begin
        if (first < 0) first = k;
        last = k;
        highs++;
      end
      if (k == cal_off_at || k == cal_off2) InCal = 1'b0;
      if (k == cal_on2) InCal = 1'b1;
      if (pd_on_after >= 0 && first >= 0 && k == first + pd_on_after) InPD = 1'b1;
    end
  endtask

  typedef struct {
    string       name;
    logic [63:0] bits;
    int          n;
    bit          simul;
    logic [3:0]  addr;
    int          exp_done;
    int          exp_err;
  } frame_vec_t;

  frame_vec_t vecs [7];

  initial begin
    int first, last, highs, d0, e0, waited;
    logic [11:0] hdr;
    logic [3:0]  addr;
    logic [15:0] data;
    logic [31:0] word;
    logic [63:0] bits;
    int          n, sel, exp_ok;

    model_reset();
    repeat (4) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);

    // Reset state
    check("rst outputs", {28'h0, OutCalRunning, FrameDone, FrameError, PoweredDown}, 32'h0);
    RdAddr = 4'h1; #1 check("rst reg1", 32'(RdData), 32'h0000_B2FF);
    RdAddr = 4'h3; #1 check("rst reg3", 32'(RdData), 32'h0000_807F);
    RdAddr = 4'h5; #1 check("rst reg5", 32'(RdData), 32'h0000_0000);

    // Directed frame table
    vecs[0] = '{"good_abcd",  {32'h0, 32'h0011_ABCD},          32, 1'b0, 4'h1, 1, 0};
    vecs[1] = '{"bad_header", {32'h0, 32'h0021_1234},          32, 1'b0, 4'h1, 0, 1};
    vecs[2] = '{"short_31",   {32'h0, 32'h0011_5555} >> 1,     31, 1'b0, 4'h1, 0, 1};
    vecs[3] = '{"long_34",    {30'h0, 32'h0011_6666, 2'b01},   34, 1'b0, 4'h1, 0, 1};
    vecs[4] = '{"good_qoff",  {32'h0, 32'h001A_5A5A},          32, 1'b0, 4'hA, 1, 0};
    vecs[5] = '{"no_default", {32'h0, 32'h0015_BEEF},          32, 1'b0, 4'h5, 1, 0};
    vecs[6] = '{"simul_end",  {32'h0, 32'h0013_1357},          32, 1'b1, 4'h3, 1, 0};
    for (int i = 0; i < 7; i++)
      run_frame(vecs[i].name, vecs[i].bits, vecs[i].n, vecs[i].simul,
                vecs[i].addr, vecs[i].exp_done, vecs[i].exp_err);

    // Random frames against the register-file model
    for (int i = 0; i < 20; i++) begin
      hdr  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'h001;
      addr = 4'($urandom);
      data = 16'($urandom);
      word = {hdr, addr, data};
      sel  = int'($urandom_range(0, 5));
      n    = (sel == 0) ? 31 : (sel == 1) ? 33 : (sel == 2) ? 34 : 32;
      bits = (n == 31) ? {32'h0, word} >> 1 :
             (n == 33) ? {31'h0, word, 1'($urandom)} :
             (n == 34) ? {30'h0, word, 2'($urandom)} : {32'h0, word};
      exp_ok = (n == 32 && hdr == 12'h001) ? 1 : 0;
      run_frame($sformatf("rand%0d", i), bits, n, 1'b0, addr, exp_ok, 1 - exp_ok);
    end
    for (int a = 0; a < 16; a++) begin
      RdAddr = 4'(a);
      #1 check($sformatf("sweep reg%0d", a), 32'(RdData), 32'(model_regs[a]));
    end

    // Calibration request, with a second request during the run window
    @(negedge Clock);
    InCal = 1'b1;
    observe_cal(45, 3, 9, 13, -1, first, last, highs);
    check("cal latency", first, CAL_LAT);
    check("cal width", highs, CAL_CYCLES);
    check("cal contiguous", last - first + 1, CAL_CYCLES);

    // Power-down status and cal requests ignored while InPD is high
    InPD = 1'b1;
    repeat (10) @(negedge Clock);
    check("pd without pdq", 32'(PoweredDown), 32'h0);
    InPDQ = 1'b1;
    repeat (10) @(negedge Clock);
    check("pd with pdq", 32'(PoweredDown), 32'h1);
    InCal = 1'b1;
    observe_cal(25, 4, -1, -1, -1, first, last, highs);
    check("cal blocked by pd", highs, 0);
    run_frame("write_while_pd", {32'h0, 32'h0012_4242}, 32, 1'b0, 4'h2, 1, 0);

    // Wake triggers calibration; PD reasserted 5 cycles into the run aborts it
    InPDQ = 1'b0;
    @(negedge Clock);
    InPD = 1'b0;
    observe_cal(40, -1, -1, -1, 5, first, last, highs);
    check("wake cal latency", first, CAL_LAT);
    check("abort drop timing", 32'((last >= first + 5) && (last <= first + 9)), 32'h1);
    check("abort shortened", 32'(highs < CAL_CYCLES), 32'h1);
    check("abort final low", 32'(OutCalRunning), 32'h0);
    InPD = 1'b0;
    repeat (40) @(negedge Clock);

    // Reset in the middle of a frame
    d0 = done_cnt;
    e0 = err_cnt;
    word = 32'h0011_7777;
    InSelect = 1'b0;
    repeat (8) @(negedge Clock);
    for (int i = 31; i >= 15; i--) send_bit(word[i], 1'b0);
    pulse_reset();
    model_reset();
    for (int i = 14; i >= 0; i--) send_bit(word[i], 1'b0);
    InSclk = 1'b0;
    repeat (4) @(negedge Clock);
    InSelect = 1'b1;
    repeat (16) @(negedge Clock);
    check("midframe rst done", done_cnt - d0, 0);
    check("midframe rst err", err_cnt - e0, 0);
    RdAddr = 4'h1; #1 check("midframe rst reg1", 32'(RdData), 32'h0000_B2FF);
    RdAddr = 4'h5; #1 check("midframe rst reg5", 32'(RdData), 32'h0000_0000);

    // Reset during the calibration run window
    @(negedge Clock);
    InCal = 1'b1;
    repeat (4) @(negedge Clock);
    InCal  = 1'b0;
    waited = 0;
    while (!OutCalRunning && waited < 20) begin
      @(negedge Clock);
      waited++;
    end
    check("cal reached run", 32'(OutCalRunning), 32'h1);
    repeat (3) @(negedge Clock);
    d0 = done_cnt;
    e0 = err_cnt;
    pulse_reset();
    observe_cal(25, -1, -1, -1, -1, first, last, highs);
    check("cal rst low", highs, 0);
    check("cal rst no pulses", (done_cnt - d0) + (err_cnt - e0), 0);

    run_frame("post_reset", {32'h0, 32'h0011_C0DE}, 32, 1'b0, 4'h1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_serial_responder.md
Name: adc_serial_responder

Overview:
- Synthesizable model of the ADC side of the ADC control interface: 3-wire serial config port, power-down pins and the calibration handshake.
- Decodes 32-bit serial write frames into a 16-entry x 16-bit register file.
- Asserts OutCalRunning for a fixed window after a calibration request.
- Used as the ADC stand-in for closed-loop simulation and on-board loopback against the ADC control FSM.

Parameters:
- CAL_DELAY, 4: Clock cycles from detected cal request to OutCalRunning high.
- CAL_CYCLES, 14: Clock cycles OutCalRunning stays high.
- AUTO_CAL_ON_WAKE, 1: when 1, a falling edge of InPD also starts calibration.

Ports:
- Clock  in  1  system clock; every other input is asynchronous to it.
- Reset  in  1  synchronous, active-high reset.
- InSclk  in  1  serial clock from the controller; Clock must be at least 4x InSclk.
- InSdata  in  1  serial data, MSB first, sampled on InSclk rising edge.
- InSelect  in  1  frame select, active low.
- InPD  in  1  power-down, I channel.
- InPDQ  in  1  power-down, Q channel; status only.
- InCal  in  1  calibration request.
- RdAddr  in  4  register-file read address.
- RdData  out  16  register contents at RdAddr; combinational read.
- OutCalRunning  out  1  calibration in progress.
- FrameDone  out  1  one-cycle pulse on each committed write.
- FrameError  out  1  one-cycle pulse on each rejected frame.
- PoweredDown  out  1  registered copy of synchronized (InPD & InPDQ).

Behaviour:
- Input sync: InSclk, InSdata, InSelect, InPD and InCal each pass through 2 flops, plus a third flop for edge detect. Edges are seen on stage-2 vs stage-3.
- Reset: frame FSM goes to IDLE and the cal FSM to C_IDLE. Bit counter and shift register clear. Outputs OutCalRunning, FrameDone, FrameError and PoweredDown are 0. Register file loads package defaults.
- Frame FSM states: IDLE, SHIFT, WAIT_DESEL.
  - IDLE: a synchronized InSelect fall moves to SHIFT and clears the counter and shifter.
  - SHIFT: each InSclk rise shifts InSdata into bit 0 and increments the 6-bit counter.
  - Select rises with count==32 and shifter[31:20]==12'h001: write shifter[15:0] to reg[shifter[19:16]], pulse FrameDone, go to IDLE.
  - Select rises with count!=32 or a bad header: pulse FrameError, no write, go to IDLE.
  - A 33rd InSclk rise pulses FrameError and moves to WAIT_DESEL. Further clocks are ignored; Select rise returns to IDLE with no second pulse.
  - Simultaneous InSclk rise and Select rise in one cycle: the shift is applied first, then the Select-rise rules are evaluated.
- Write visibility: RdData shows the new value the cycle after FrameDone. Writes to addresses with no default are still stored.
- Cal FSM states: C_IDLE, C_WAIT, C_RUN.
  - Trigger (C_IDLE only): a synchronized InCal rise with sync InPD low, or an InPD fall when AUTO_CAL_ON_WAKE=1.
  - Trigger loads a down-counter with CAL_DELAY-1 and enters C_WAIT.
  - C_WAIT at 0: load CAL_CYCLES-1, enter C_RUN, OutCalRunning goes high the same edge.
  - C_RUN at 0: OutCalRunning low, back to C_IDLE.
  - Latency: OutCalRunning rises exactly CAL_DELAY+3 Clock edges after the first edge that samples InCal high.
  - InCal edges outside C_IDLE are ignored; there is no queueing.
  - Sync InPD high in C_WAIT or C_RUN aborts to C_IDLE; OutCalRunning is low on the next edge.
  - Register file and frame FSM are unaffected by PD; serial writes are accepted while powered down.
- Reset mid-frame or mid-cal: immediate return to the idle states. No FrameDone or FrameError pulse is produced.

Decomposition:
- Package adc_if_pkg holds:
  - FRAME_BITS=32, HEADER=12'h001, address/data field positions.
  - Register addresses: CONFIG=4'h1, I_OFFSET=4'h2, I_FSR=4'h3, Q_OFFSET=4'hA, Q_FSR=4'hB.
  - Defaults: 16'hB2FF, 16'h007F, 16'h807F, 16'h007F, 16'h807F; all others 0.
  - State encodings for both FSMs.
- One sub-module, sync_edge: 2-flop synchronizer plus edge detector with outputs level, rise and fall. Instantiated per input.

Test Plan:
- After reset: RdData@1=16'hB2FF, @3=16'h807F, @5=0; all outputs 0.
- Frame 32'h001_1_ABCD at Sclk=Clock/8 -> single FrameDone pulse; RdData@1=16'hABCD the next cycle.
- Frames with header 12'h002, with 31 bits, and with 34 bits -> one FrameError each; reg 1 unchanged.
- InCal 0->1 with InPD=0 -> OutCalRunning high at edge 7 after sampling (CAL_DELAY+3), high exactly 14 cycles; a second InCal pulse during C_RUN is ignored.
- InPD 1->0 with AUTO_CAL_ON_WAKE=1 -> cal window runs. InPD set high 5 cycles into C_RUN -> OutCalRunning low next edge, FSM in C_IDLE.
- Reset pulsed at bit 17 of a frame and again during C_RUN -> no pulses, registers at defaults, the next full frame commits correctly.
